lc3_pipeline_controller: RTL and testbench
==========================================

// Module: lc3_pipeline_controller
// PURPOSE
// - Sequences the LC-3 five-stage datapath (fetch, decode, execute, writeback, updatePC).
// - Drives the per-stage enables, memory-access state, branch-taken and ALU bypass selects.
// - Reads decode-stage IR and the execute-stage outputs (IR_Exec, NZP) plus PSR.
// - Sits beside the execute stage and stalls or flushes the pipeline for memory and control ops.
// PARAMETERS
// - FILL_DEPTH   4   cycles to refill the pipeline after reset or branch (FILL cnt 0..FILL_DEPTH-1)
// - STALL_CNT_W  16  width of optional stall counter
// PORTS
// - clock            in   1   system clock, rising edge
// - reset            in   1   synchronous, active-high
// - complete_instr   in   1   instruction memory response valid
// - complete_data    in   1   data memory response valid
// - IR               in   16  instruction in decode stage
// - IR_Exec          in   16  instruction in execute stage
// - NZP              in   3   execute-stage condition field for branches
// - psr              in   3   processor status {N,Z,P}
// - enable_fetch     out  1   fetch stage enable
// - enable_decode    out  1   decode stage enable
// - enable_execute   out  1   execute stage enable
// - enable_writeback out  1   writeback stage enable
// - enable_updatePC  out  1   PC register load enable
// - br_taken         out  1   PC mux selects branch/JMP target
// - mem_state        out  2   0=read, 1=read-indirect, 2=write, 3=idle
// - bypass_alu_1     out  1   forward aluout to execute src1
// - bypass_alu_2     out  1   forward aluout to execute src2
// BEHAVIOUR
// - One clock domain, clock; reset is synchronous and active-high.
// - Reset: state=FILL, cnt=0, mem_served=0, all enables 0, br_taken 0, mem_state 3.
// - Opcode classes, from IR[15:12] or IR_Exec[15:12]:
//   - ALU: 0001/0101/1001
//   - LD/LDR: 0010/0110; LDI: 1010
//   - ST/STR: 0011/0111; STI: 1011
//   - CTRL: 0000 (BR) and 1100 (JMP)
// - FILL, indexed by cnt:
//   - fetch and updatePC are 1.
//   - decode is 1 when cnt>=1, execute when cnt>=2, writeback when cnt>=3.
//   - cnt increments each cycle; at cnt==FILL_DEPTH-1 the next state is RUN.
// - RUN: all enables 1. Mealy stall checks, in priority order:
//   - (a) IR_Exec is a memory op and mem_served==0: all enables 0 this cycle.
//     Next state is MEM_IND for LDI/STI, MEM_RD for LD/LDR, MEM_WR for ST/STR.
//   - (b) else if IR is CTRL: next state is BR with cnt=0.
// - MEM_IND: mem_state=1, all enables 0. On complete_data go to MEM_RD (LDI) or MEM_WR (STI); else hold.
// - MEM_RD: mem_state=0, enables 0 except writeback=complete_data. On complete_data go to RUN and set mem_served=1.
// - MEM_WR: mem_state=2, all enables 0. On complete_data go to RUN and set mem_served=1.
// - mem_served clears on any RUN cycle with enable_execute=1, so the same IR_Exec never retriggers.
// - BR, cnt 0: fetch, decode and updatePC are 0; execute and writeback are 1 (branch executes).
// - BR, cnt 1:
//   - br_taken = 1 for JMP, or |(NZP & psr) for BR; this is a registered output, valid this cycle.
//   - enable_updatePC=1; all other enables 0.
//   - Next state FILL with cnt=0; br_taken returns to 0.
// - complete_instr==0 in FILL or RUN: all enables 0, state and cnt hold. It is ignored in MEM_* and BR.
// - mem_state=3 in every state except MEM_*.
// - Bypasses: combinational, valid only when IR_Exec is an ALU op.
//   - bypass_alu_1 = (IR_Exec[11:9]==IR[8:6]).
//   - bypass_alu_2 = (IR_Exec[11:9]==IR[2:0]) && IR[5]==0 && IR is ALU.
// - Reset asserted mid-MEM or mid-BR returns to FILL cnt=0 next cycle; a pending memory op is abandoned.
// CONFIGURATION
// - LC3_CTRL_STALL_CNT_EN defined:
//   - adds output port stall_cnt [STALL_CNT_W-1:0].
//   - counts cycles spent in MEM_* or BR, and RUN cycles with all enables 0.
//   - saturates at all-ones; cleared by reset.
// - LC3_CTRL_STALL_CNT_EN undefined: port and counter are absent; all other behaviour identical.
// TESTING
// - Reset release, ADD stream:
//   - enables rise fetch/updatePC@1, decode@2, execute@3, writeback@4.
//   - then steady all-1, mem_state=3.
// - IR_Exec=LDR (0x6xxx) in RUN, complete_data=1:
//   - one stall cycle, then MEM_RD with mem_state=0 and writeback=1 for one cycle.
//   - RUN resumes; mem_served blocks retrigger.
// - IR_Exec=STI (0xBxxx), complete_data low for 3 cycles:
//   - MEM_IND holds with mem_state=1 until complete_data.
//   - then MEM_WR with mem_state=2, then RUN.
// - IR=BRz (0x0400), psr=3'b010, NZP=3'b010: BR sequence, br_taken=1 at cnt1 with updatePC=1, then FILL.
//   - Repeat with psr=3'b001: br_taken=0.
// - IR_Exec=ADD R3 (0x16C1), IR=ADD R4,R3,R3 (0x18C3): bypass_alu_1=1 and bypass_alu_2=1.
//   - IR=0x18E3 (imm): bypass_alu_2=0.
// - Reset asserted during MEM_IND: next cycle FILL cnt=0 with all outputs at reset values.
//   - With LC3_CTRL_STALL_CNT_EN defined: stall_cnt=0.

Source files
------------

// File: rtl/lc3_pipeline_controller_if.sv
// Control/status bundle between the LC-3 datapath and its pipeline controller.
// Carries stall_cnt only when LC3_CTRL_STALL_CNT_EN is defined.
interface lc3_pipeline_controller_if #(
    parameter int unsigned STALL_CNT_W = 16
);
    logic        complete_instr;
    logic        complete_data;
    logic [15:0] IR;
    logic [15:0] IR_Exec;
    logic [2:0]  NZP;
    logic [2:0]  psr;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        enable_updatePC;
    logic        br_taken;
    logic [1:0]  mem_state;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
`ifdef LC3_CTRL_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;
`else
    localparam int unsigned stall_cnt_w_unused = STALL_CNT_W;
`endif

    // Controller side.
    modport master (
        input  complete_instr, complete_data, IR, IR_Exec, NZP, psr,
        output enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC,
        output br_taken, mem_state, bypass_alu_1, bypass_alu_2
`ifdef LC3_CTRL_STALL_CNT_EN
        , output stall_cnt
`endif
    );

    // Datapath side.
    modport slave (
        output complete_instr, complete_data, IR, IR_Exec, NZP, psr,
        input  enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC,
        input  br_taken, mem_state, bypass_alu_1, bypass_alu_2
`ifdef LC3_CTRL_STALL_CNT_EN
        , input stall_cnt
`endif
    );
endinterface

// File: rtl/lc3_pipeline_controller.sv
// LC-3 five-stage pipeline sequencer: stage enables, memory stalls, branch flush, ALU bypass.
// Define LC3_CTRL_STALL_CNT_EN to add the saturating stall_cnt output.
module lc3_pipeline_controller #(
    parameter int unsigned FILL_DEPTH  = 4,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    lc3_pipeline_controller_if.master bus
);
    localparam int unsigned CNT_W = (FILL_DEPTH > 2) ? $clog2(FILL_DEPTH) : 1;

    localparam logic [3:0] OpBr  = 4'b0000;
    localparam logic [3:0] OpJmp = 4'b1100;
    localparam logic [3:0] OpLdi = 4'b1010;
    localparam logic [3:0] OpSti = 4'b1011;

    typedef enum logic [2:0] {StFill, StRun, StMemInd, StMemRd, StMemWr, StBr} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_served_q, mem_served_d;
    logic             br_taken_q, br_taken_d;
    logic             is_jmp_q, is_jmp_d;

    logic en_f, en_d, en_e, en_w, en_pc;
    logic [1:0] mem_state;

    logic [3:0] op_dec, op_exe;
    logic dec_is_alu, dec_is_ctrl, exe_is_alu, exe_is_ld, exe_is_st, exe_is_ind, exe_is_mem;

    assign op_dec      = bus.IR[15:12];
    assign op_exe      = bus.IR_Exec[15:12];
    assign dec_is_alu  = op_dec inside {4'b0001, 4'b0101, 4'b1001};
    assign dec_is_ctrl = (op_dec == OpBr) || (op_dec == OpJmp);
    assign exe_is_alu  = op_exe inside {4'b0001, 4'b0101, 4'b1001};
    assign exe_is_ld   = op_exe inside {4'b0010, 4'b0110};
    assign exe_is_st   = op_exe inside {4'b0011, 4'b0111};
    assign exe_is_ind  = (op_exe == OpLdi) || (op_exe == OpSti);
    assign exe_is_mem  = exe_is_ld || exe_is_st || exe_is_ind;

    logic unused_ir_bits;
    assign unused_ir_bits = ^{bus.IR[11:9], bus.IR[4:3], bus.IR_Exec[8:0]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_served_d = mem_served_q;
        br_taken_d   = 1'b0;
        is_jmp_d     = is_jmp_q;
        en_f         = 1'b0;
        en_d         = 1'b0;
        en_e         = 1'b0;
        en_w         = 1'b0;
        en_pc        = 1'b0;
        mem_state    = 2'd3;

        unique case (state_q)
            StFill: begin
                if (bus.complete_instr) begin
                    en_f  = 1'b1;
                    en_pc = 1'b1;
                    en_d  = 32'(cnt_q) >= 32'd1;
                    en_e  = 32'(cnt_q) >= 32'd2;
                    en_w  = 32'(cnt_q) >= 32'd3;
                    if (32'(cnt_q) == FILL_DEPTH - 1) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StRun: begin
                if (bus.complete_instr) begin
                    // An unserved memory op in execute freezes the whole pipe.
                    if (exe_is_mem && !mem_served_q) begin
                        if (exe_is_ind)     state_d = StMemInd;
                        else if (exe_is_ld) state_d = StMemRd;
                        else                state_d = StMemWr;
                    end else begin
                        en_f         = 1'b1;
                        en_d         = 1'b1;
                        en_e         = 1'b1;
                        en_w         = 1'b1;
                        en_pc        = 1'b1;
                        mem_served_d = 1'b0;
                        if (dec_is_ctrl) begin
                            state_d  = StBr;
                            cnt_d    = '0;
                            is_jmp_d = (op_dec == OpJmp);
                        end
                    end
                end
            end
            StMemInd: begin
                mem_state = 2'd1;
                if (bus.complete_data) begin
                    state_d = (op_exe == OpLdi) ? StMemRd : StMemWr;
                end
            end
            StMemRd: begin
                mem_state = 2'd0;
                en_w      = bus.complete_data;
                if (bus.complete_data) begin
                    state_d      = StRun;
                    mem_served_d = 1'b1;
                end
            end
            StMemWr: begin
                mem_state = 2'd2;
                if (bus.complete_data) begin
                    state_d      = StRun;
                    mem_served_d = 1'b1;
                end
            end
            StBr: begin
                if (cnt_q == '0) begin
                    en_e       = 1'b1;
                    en_w       = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    br_taken_d = is_jmp_q || (|(bus.NZP & bus.psr));
                end else begin
                    en_pc   = 1'b1;
                    state_d = StFill;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StFill;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StFill;
            cnt_q        <= '0;
            mem_served_q <= 1'b0;
            br_taken_q   <= 1'b0;
            is_jmp_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_served_q <= mem_served_d;
            br_taken_q   <= br_taken_d;
            is_jmp_q     <= is_jmp_d;
        end
    end

    // Outputs sit at their reset values for as long as reset is held.
    always_comb begin
        bus.enable_fetch     = en_f && !reset;
        bus.enable_decode    = en_d && !reset;
        bus.enable_execute   = en_e && !reset;
        bus.enable_writeback = en_w && !reset;
        bus.enable_updatePC  = en_pc && !reset;
        bus.br_taken         = br_taken_q && !reset;
        bus.mem_state        = reset ? 2'd3 : mem_state;
        bus.bypass_alu_1     = exe_is_alu && (bus.IR_Exec[11:9] == bus.IR[8:6]);
        bus.bypass_alu_2     = exe_is_alu && (bus.IR_Exec[11:9] == bus.IR[2:0]) &&
                               !bus.IR[5] && dec_is_alu;
    end

`ifdef LC3_CTRL_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic                   stall_cycle;

    assign stall_cycle = (state_q inside {StMemInd, StMemRd, StMemWr, StBr}) ||
                         ((state_q == StRun) && !(en_f || en_d || en_e || en_w || en_pc));

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall_cycle && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    localparam int unsigned stall_cnt_w_unused = STALL_CNT_W;
`endif
endmodule

// File: tb/tb_lc3_pipeline_controller.sv
// Scoreboard bench for lc3_pipeline_controller: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_lc3_pipeline_controller;
    localparam logic [15:0] Add0 = 16'h1000;
    localparam logic [15:0] Add1 = 16'h1261;

    logic clock;
    logic reset;

    lc3_pipeline_controller_if #(.STALL_CNT_W(16)) bus_if ();

    lc3_pipeline_controller #(
        .FILL_DEPTH (4),
        .STALL_CNT_W(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [4:0] en;     // {fetch, decode, execute, writeback, updatePC}
        logic       br;
        logic [1:0] ms;
        logic       bp_chk;
        logic [1:0] bp;     // {bypass_alu_1, bypass_alu_2}
        logic       sc_chk;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: the DUT presents a full output vector every cycle.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [4:0] en_act;
            logic [1:0] bp_act;
            logic       bad;
            e      = exp_q.pop_front();
            en_act = {bus_if.enable_fetch, bus_if.enable_decode, bus_if.enable_execute,
                      bus_if.enable_writeback, bus_if.enable_updatePC};
            bp_act = {bus_if.bypass_alu_1, bus_if.bypass_alu_2};
            bad    = (en_act !== e.en) || (bus_if.br_taken !== e.br) ||
                     (bus_if.mem_state !== e.ms) || (e.bp_chk && (bp_act !== e.bp));
`ifdef LC3_CTRL_STALL_CNT_EN
            if (e.sc_chk && (bus_if.stall_cnt !== 16'd0)) bad = 1'b1;
`endif
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s: got en=%b br=%b ms=%0d bp=%b, expected en=%b br=%b ms=%0d bp=%b",
                         e.tag, en_act, bus_if.br_taken, bus_if.mem_state, bp_act,
                         e.en, e.br, e.ms, e.bp);
            end
        end
    end

    task automatic cyc(input string tag, input logic [4:0] en, input logic br,
                       input logic [1:0] ms, input logic bp_chk = 1'b0,
                       input logic [1:0] bp = 2'b00, input logic sc_chk = 1'b0);
        exp_t e;
        e = '{tag, en, br, ms, bp_chk, bp, sc_chk};
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic br_seq(input string tag, input logic [15:0] ir, input logic [2:0] nzp,
                          input logic [2:0] p, input logic taken);
        bus_if.IR  = ir;
        bus_if.NZP = nzp;
        bus_if.psr = p;
        cyc({tag, "_run"}, 5'b11111, 1'b0, 2'd3);
        bus_if.IR = Add1;
        cyc({tag, "_cnt0"}, 5'b00110, 1'b0, 2'd3);
        cyc({tag, "_cnt1"}, 5'b00001, taken, 2'd3);
        cyc({tag, "_fill0"}, 5'b10001, 1'b0, 2'd3);
        cyc({tag, "_fill1"}, 5'b11001, 1'b0, 2'd3);
        cyc({tag, "_fill2"}, 5'b11101, 1'b0, 2'd3);
        cyc({tag, "_fill3"}, 5'b11111, 1'b0, 2'd3);
        cyc({tag, "_after"}, 5'b11111, 1'b0, 2'd3);
    endtask

    initial begin
        reset                 = 1'b1;
        bus_if.complete_instr = 1'b1;
        bus_if.complete_data  = 1'b0;
        bus_if.IR             = Add1;
        bus_if.IR_Exec        = Add0;
        bus_if.NZP            = 3'b000;
        bus_if.psr            = 3'b000;
        @(posedge clock);
        #1;
        cyc("reset", 5'b00000, 1'b0, 2'd3, 1'b0, 2'b00, 1'b1);
        cyc("reset_hold", 5'b00000, 1'b0, 2'd3);
        reset = 1'b0;

        cyc("fill0", 5'b10001, 1'b0, 2'd3);
        cyc("fill1", 5'b11001, 1'b0, 2'd3);
        cyc("fill2", 5'b11101, 1'b0, 2'd3);
        cyc("fill3", 5'b11111, 1'b0, 2'd3);
        cyc("run0", 5'b11111, 1'b0, 2'd3);
        cyc("run1", 5'b11111, 1'b0, 2'd3);

        bus_if.complete_instr = 1'b0;
        cyc("ci_low", 5'b00000, 1'b0, 2'd3);
        bus_if.complete_instr = 1'b1;
        cyc("ci_back", 5'b11111, 1'b0, 2'd3);

        // LDR in execute with the data response already present.
        bus_if.IR_Exec       = 16'h6000;
        bus_if.complete_data = 1'b1;
        cyc("ldr_stall", 5'b00000, 1'b0, 2'd3);
        cyc("ldr_memrd", 5'b00010, 1'b0, 2'd0);
        cyc("ldr_resume", 5'b11111, 1'b0, 2'd3);
        bus_if.IR_Exec       = Add0;
        bus_if.complete_data = 1'b0;
        cyc("ldr_next", 5'b11111, 1'b0, 2'd3);

        // STI with a slow data memory.
        bus_if.IR_Exec = 16'hB000;
        cyc("sti_stall", 5'b00000, 1'b0, 2'd3);
        for (int i = 0; i < 3; i++) cyc("sti_ind_wait", 5'b00000, 1'b0, 2'd1);
        bus_if.complete_data = 1'b1;
        cyc("sti_ind_done", 5'b00000, 1'b0, 2'd1);
        cyc("sti_memwr", 5'b00000, 1'b0, 2'd2);
        bus_if.complete_data = 1'b0;
        bus_if.IR_Exec       = Add0;
        cyc("sti_resume", 5'b11111, 1'b0, 2'd3);

        br_seq("brz_taken", 16'h0400, 3'b010, 3'b010, 1'b1);
        br_seq("brz_not", 16'h0400, 3'b010, 3'b001, 1'b0);
        br_seq("jmp", 16'hC1C0, 3'b000, 3'b001, 1'b1);

        // Bypass selects, all in steady RUN.
        bus_if.IR_Exec = 16'h16C1;
        bus_if.IR      = 16'h18C3;
        cyc("bp_both", 5'b11111, 1'b0, 2'd3, 1'b1, 2'b11);
        bus_if.IR = 16'h18E3;
        cyc("bp_imm", 5'b11111, 1'b0, 2'd3, 1'b1, 2'b10);
        bus_if.IR = 16'h1883;
        cyc("bp_src2", 5'b11111, 1'b0, 2'd3, 1'b1, 2'b01);
        bus_if.IR = 16'h1885;
        cyc("bp_none", 5'b11111, 1'b0, 2'd3, 1'b1, 2'b00);
        bus_if.IR = 16'hE0C3;
        cyc("bp_dec_not_alu", 5'b11111, 1'b0, 2'd3, 1'b1, 2'b10);
        bus_if.IR_Exec = 16'hE6C0;
        bus_if.IR      = 16'h18C3;
        cyc("bp_exe_not_alu", 5'b11111, 1'b0, 2'd3, 1'b1, 2'b00);

        // Reset while waiting in MEM_IND abandons the access.
        bus_if.IR      = Add1;
        bus_if.IR_Exec = 16'hA000;
        cyc("ldi_stall", 5'b00000, 1'b0, 2'd3);
        cyc("ldi_ind", 5'b00000, 1'b0, 2'd1);
        reset = 1'b1;
        cyc("rst_in_ind", 5'b00000, 1'b0, 2'd3);
        cyc("rst_hold", 5'b00000, 1'b0, 2'd3, 1'b0, 2'b00, 1'b1);
        reset          = 1'b0;
        bus_if.IR_Exec = Add0;
        cyc("rst_fill0", 5'b10001, 1'b0, 2'd3, 1'b0, 2'b00, 1'b1);
        cyc("rst_fill1", 5'b11001, 1'b0, 2'd3);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
